// File: rtl/tag_write_arbiter_if.sv
// Write-request handshake and tag-memory write bus between qual channels and the arbiter.
interface tag_write_arbiter_if #(
  parameter int L  = 4,
  parameter int TW = 32,
  parameter int AW = 10
);
  localparam int CW = $clog2(L);

  logic [L-1:0]     req;       // per-channel write request
  logic [L-1:0]     ack;       // per-channel write ack, one-hot or zero
  logic             mem_we;    // one strobe per stored entry
  logic [AW-1:0]    mem_addr;  // write pointer
  logic [CW+TW-1:0] mem_din;   // {channel index, timestamp}

  // Arbiter side: consumes requests, drives acks and the memory write port.
  modport slave (
    input  req,
    output ack, mem_we, mem_addr, mem_din
  );

  // Requester/observer side: drives requests, sees acks and the write port.
  modport master (
    output req,
    input  ack, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/tag_write_arbiter.sv
// Round-robin arbiter that shares one time-tag memory write port between L
// qualifier channels. Each served request stores {channel, timestamp} at an
// incrementing address, then completes a 4-phase ack handshake.
module tag_write_arbiter #(
  parameter int L  = 4,
  parameter int TW = 32,
  parameter int AW = 10
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  tag_write_arbiter_if.slave   bus,
  output logic [AW:0]          count,
  output logic                 full,
  output logic [15:0]          dropped,
  output logic                 busy
);

  localparam int CW = $clog2(L);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_e;
  typedef enum logic {M_WR, M_DROP} mode_e;

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] idx;
  } pick_t;

  // First requesting channel at or above the pointer, wrapping modulo L.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  function automatic pick_t rr_pick(input logic [L-1:0] r, input logic [CW-1:0] p);
    pick_t         res;
    int            j;
    logic [CW-1:0] k;
    res = '0;
    for (int i = L - 1; i >= 0; i--) begin
      j = (int'(p) + i) % L;
      k = CW'(j);
      if (r[k]) begin
        res.valid = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    gidx_q, gidx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             start_d_q, start_d_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic [15:0]      dropped_q, dropped_d;
  logic             mem_we_q, mem_we_d;
  logic [CW+TW-1:0] mem_din_q, mem_din_d;
  logic [L-1:0]     ack_q, ack_d;

  pick_t            pick;
  logic [CW-1:0]    rr_next;

  // Candidate grant and the pointer value that follows the current grant.
  always_comb begin
    pick    = rr_pick(bus.req, rr_q);
    rr_next = (gidx_q == CW'(L - 1)) ? '0 : gidx_q + 1'b1;
  end

  // Next-state logic for the handshake FSM, timestamp and run counters.
  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    rr_d      = rr_q;
    gidx_d    = gidx_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    full_d    = full_q;
    dropped_d = dropped_q;
    mem_we_d  = mem_we_q;
    mem_din_d = mem_din_q;
    ack_d     = ack_q;
    start_d_d = start;
    tcnt_d    = start ? tcnt_q + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        if (pick.valid) begin
          state_d   = S_GRANT;
          gidx_d    = pick.idx;
          mode_d    = (start && !full_q) ? M_WR : M_DROP;
          mem_we_d  = start && !full_q;
          mem_din_d = {pick.idx, tcnt_q};
        end
      end
      S_GRANT: begin
        mem_we_d = 1'b0;
        if (mode_q == M_WR) begin
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          full_d  = (count_q + 1'b1 == DEPTH);
        end else if (start && dropped_q != 16'hFFFF) begin
          // Full-window drops are counted; out-of-window requests are acked silently.
          dropped_d = dropped_q + 16'd1;
        end
        ack_d   = L'(1) << gidx_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!bus.req[gidx_q]) begin
          ack_d   = '0;
          rr_d    = rr_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Arming a new run wins over any write-side increment in the same cycle.
    if (start && !start_d_q) begin
      wptr_d    = '0;
      count_d   = '0;
      full_d    = 1'b0;
      dropped_d = '0;
    end
  end

  // State register; reset drops ack at once and discards any write in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      mode_q    <= M_WR;
      rr_q      <= '0;
      gidx_q    <= '0;
      tcnt_q    <= '0;
      start_d_q <= 1'b0;
      wptr_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      dropped_q <= '0;
      mem_we_q  <= 1'b0;
      mem_din_q <= '0;
      ack_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      mode_q    <= mode_d;
      rr_q      <= rr_d;
      gidx_q    <= gidx_d;
      tcnt_q    <= tcnt_d;
      start_d_q <= start_d_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      dropped_q <= dropped_d;
      mem_we_q  <= mem_we_d;
      mem_din_q <= mem_din_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = wptr_q;
  assign bus.mem_din  = mem_din_q;
  assign count        = count_q;
  assign full         = full_q;
  assign dropped      = dropped_q;
  assign busy         = (state_q != S_IDLE);

endmodule
